// File: rtl/axi_master_fsm_pkg.sv
// Shared encodings for the AXI3 master handshake engine: FSM states and
// AXI burst/size/response codes.
package axi_master_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_master_fsm.sv
// AXI3 master handshake engine: turns the arbiter's latched read/write request
// into AR/R or AW/W/B handshakes and returns completion pulses upstream.
module axi_master_fsm
  import axi_master_fsm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ID_W-1:0]   ar_id_i,
  input  logic [ADDR_W-1:0] ar_addr_i,
  input  logic [3:0]        ar_len_i,
  input  logic [2:0]        ar_size_i,
  input  logic [1:0]        ar_burst_i,
  input  logic [ID_W-1:0]   aw_id_i,
  input  logic [ADDR_W-1:0] aw_addr_i,
  input  logic [3:0]        aw_len_i,
  input  logic [2:0]        aw_size_i,
  input  logic [1:0]        aw_burst_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast,
  output logic              wready,
  output logic              wlast,
  output logic              bus_err,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ID_W-1:0]   m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ID_W-1:0]   m_wid,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [ID_W-1:0]   m_bid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  state_e              state_q;
  logic [ID_W-1:0]     ar_id_q;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [3:0]          ar_len_q;
  logic [2:0]          ar_size_q;
  logic [1:0]          ar_burst_q;
  logic [ID_W-1:0]     aw_id_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [2:0]          aw_size_q;
  logic [1:0]          aw_burst_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [3:0]          beat_cnt_q;
  logic                rd_err_q;
  logic                overrun_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic                wready_q;
  logic                bus_err_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;

  logic done_pulse_d;
  logic aw_pend_d;
  logic w_pend_d;
  logic rd_err_d;

  // A completion pulse this cycle blocks request sampling so upstream can drop req.
  assign done_pulse_d = (rvalid_q & rlast_q) | wready_q;
  assign aw_pend_d    = awvalid_q & ~m_awready;
  assign w_pend_d     = wvalid_q & ~m_wready;
  assign rd_err_d     = rd_err_q | overrun_q | resp_is_err(m_rresp) | (beat_cnt_q != ar_len_q);

  // Transaction FSM, field latches, beat counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ar_id_q    <= {ID_W{1'b0}};
      ar_addr_q  <= {ADDR_W{1'b0}};
      ar_len_q   <= 4'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
      aw_id_q    <= {ID_W{1'b0}};
      aw_addr_q  <= {ADDR_W{1'b0}};
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      wdata_q    <= {DATA_W{1'b0}};
      wstrb_q    <= {STRB_W{1'b0}};
      beat_cnt_q <= 4'd0;
      rd_err_q   <= 1'b0;
      overrun_q  <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      wready_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      wready_q  <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!done_pulse_d && wr_req) begin
            aw_id_q    <= aw_id_i;
            aw_addr_q  <= aw_addr_i;
            aw_size_q  <= aw_size_i;
            aw_burst_q <= aw_burst_i;
            wdata_q    <= wdata_i;
            wstrb_q    <= wstrb_i;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            state_q    <= ST_WR_REQ;
          end else if (!done_pulse_d && rd_req) begin
            ar_id_q    <= ar_id_i;
            ar_addr_q  <= ar_addr_i;
            ar_len_q   <= ar_len_i;
            ar_size_q  <= ar_size_i;
            ar_burst_q <= ar_burst_i;
            beat_cnt_q <= 4'd0;
            rd_err_q   <= 1'b0;
            overrun_q  <= 1'b0;
            arvalid_q  <= 1'b1;
            state_q    <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_rvalid) begin
            rdata_q    <= m_rdata;
            rvalid_q   <= 1'b1;
            beat_cnt_q <= beat_cnt_q + 4'd1;
            if (m_rlast) begin
              rlast_q   <= 1'b1;
              bus_err_q <= rd_err_d;
              rready_q  <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              rd_err_q <= rd_err_q | resp_is_err(m_rresp);
              // Remember a non-final beat at index arlen: the counter may wrap later.
              if (beat_cnt_q == ar_len_q) begin
                overrun_q <= 1'b1;
              end
            end
          end
        end
        ST_WR_REQ: begin
          if (!aw_pend_d) begin
            awvalid_q <= 1'b0;
          end
          if (!w_pend_d) begin
            wvalid_q <= 1'b0;
          end
          if (!aw_pend_d && !w_pend_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_bvalid) begin
            bready_q  <= 1'b0;
            wready_q  <= 1'b1;
            bus_err_q <= resp_is_err(m_bresp);
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign wready    = wready_q;
  assign wlast     = wready_q;
  assign bus_err   = bus_err_q;

  assign m_arid    = ar_id_q;
  assign m_araddr  = ar_addr_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arburst = ar_burst_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  // Writes are always single-beat, whatever length upstream requests.
  assign m_awid    = aw_id_q;
  assign m_awaddr  = aw_addr_q;
  assign m_awlen   = 4'd0;
  assign m_awsize  = aw_size_q;
  assign m_awburst = aw_burst_q;
  assign m_awvalid = awvalid_q;
  assign m_wid     = aw_id_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wlast   = wvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

  logic unused_inputs;
  assign unused_inputs = ^{aw_len_i, m_rid, m_bid};

endmodule
